// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 core: DMEM size defaults and the DMEM responder state encoding.
package swt16_pkg;

  localparam int unsigned DMEM_ADDR_WIDTH_DEFAULT = 12;
  localparam int unsigned DMEM_WORD_WIDTH_DEFAULT = 16;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;

  typedef enum logic {
    StClear = ST_CLEAR,
    StReady = ST_READY
  } dmem_state_e;

endpackage

// File: rtl/dmem_ram_array.sv
// Single write port, single synchronous read port RAM with no reset; maps onto block RAM.
module dmem_ram_array #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_word,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_word
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [Depth];

  // Read-first: a same-address write is not visible until the next read.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
    rd_word <= mem[rd_addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data memory behind the MEM stage: zero-fills itself after reset, then serves 1-cycle reads
// with write-first bypass and single-cycle writes.
module dmem_responder
  import swt16_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_WIDTH = swt16_pkg::DMEM_ADDR_WIDTH_DEFAULT,
  parameter int unsigned DMEM_WORD_WIDTH = swt16_pkg::DMEM_WORD_WIDTH_DEFAULT,
  parameter bit          CLEAR_ON_RESET  = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_wr_word,
  input  logic                       in_mem_write_en,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_rd_word,
  output logic                       out_init_done
);

  localparam dmem_state_e ResetState = CLEAR_ON_RESET ? StClear : StReady;
  localparam logic [DMEM_ADDR_WIDTH:0] ClrLast = {1'b0, {DMEM_ADDR_WIDTH{1'b1}}};

  dmem_state_e                state_q, state_d;
  logic [DMEM_ADDR_WIDTH:0]   clr_addr_q, clr_addr_d;
  logic                       init_done_q, init_done_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       byp_hit_q, byp_hit_d;
  logic [DMEM_WORD_WIDTH-1:0] byp_word_q;

  logic                       ram_we;
  logic [DMEM_ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DMEM_WORD_WIDTH-1:0] ram_wr_word;
  logic [DMEM_WORD_WIDTH-1:0] ram_rd_word;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    init_done_d = init_done_q;
    rd_valid_d  = 1'b0;
    byp_hit_d   = 1'b0;
    ram_we      = in_mem_write_en;
    ram_wr_addr = in_mem_wr_addr;
    ram_wr_word = in_mem_wr_word;
    unique case (state_q)
      StClear: begin
        // The clear owns the write port; port writes are dropped.
        ram_we      = 1'b1;
        ram_wr_addr = clr_addr_q[DMEM_ADDR_WIDTH-1:0];
        ram_wr_word = '0;
        clr_addr_d  = clr_addr_q + 1'b1;
        if (clr_addr_q == ClrLast) begin
          state_d     = StReady;
          init_done_d = 1'b1;
        end
      end
      StReady: begin
        init_done_d = 1'b1;
        rd_valid_d  = 1'b1;
        byp_hit_d   = in_mem_write_en && (in_mem_wr_addr == in_mem_rd_addr);
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ResetState;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      byp_hit_q   <= 1'b0;
      byp_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
      rd_valid_q  <= rd_valid_d;
      byp_hit_q   <= byp_hit_d;
      byp_word_q  <= in_mem_wr_word;
    end
  end

  dmem_ram_array #(
    .ADDR_WIDTH (DMEM_ADDR_WIDTH),
    .WORD_WIDTH (DMEM_WORD_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ram_we),
    .wr_addr (ram_wr_addr),
    .wr_word (ram_wr_word),
    .rd_addr (in_mem_rd_addr),
    .rd_word (ram_rd_word)
  );

  // The RAM read register has no reset, so gate it until a READY-cycle read has landed.
  assign out_mem_rd_word = !rd_valid_q ? '0 : (byp_hit_q ? byp_word_q : ram_rd_word);
  assign out_init_done   = init_done_q;

endmodule
